regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential debug reader for the 32×64-bit register file. On `start` it walks register addresses 0..31 through one spare combinational read port, captures each 64-bit value, and streams it out byte-serially, little-endian, over a valid/ready interface toward the host/debug link. It sits beside the datapath and owns only a read address. It never writes the register file.

## Interface
Parameters:
- `NREGS`, 32, number of registers dumped (addresses 0..NREGS-1).
- `ABITS`, 5, register address width.
- `DW`, 64, register data width; must be a multiple of 8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `ra`  out  ABITS  read address to the register-file read port.
- `rd`  in  DW  combinational read data for `ra`.
- `tx_data`  out  8  current byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `tx_last`  out  1  high with the final byte of register NREGS-1.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- The FSM has four states: IDLE, LOAD, SEND, DONE.
- IDLE, with `start`=1: set idx←0 and go to LOAD. With `start`=0, stay.
- LOAD (always 1 cycle): `ra`=idx. At the edge, set shreg←`rd`, bcnt←0, and go to SEND.
- SEND: `tx_valid`=1 and `tx_data`=shreg[7:0].
  - On a transfer with bcnt<DW/8-1: shreg←shreg>>8, bcnt++.
  - On a transfer with bcnt=DW/8-1: if idx=NREGS-1 go to DONE; otherwise idx++ and go to LOAD.
  - With no transfer, hold shreg, bcnt and state.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `ra` equals idx in every state.
- `tx_last` = SEND && idx=NREGS-1 && bcnt=DW/8-1.
- `start` is ignored in LOAD, SEND and DONE. It is not queued.
- There is no snapshot coherence. Each register is captured at its own LOAD cycle, so a datapath write to a register not yet loaded appears in the dump. Address 31 reads 0 from the file and is sent as eight 0x00 bytes.
- Reset values: state=IDLE, idx=0, bcnt=0, shreg=0. `ra`=0, `tx_valid`=0, `tx_data`=0x00, `tx_last`=0, `busy`=0, `done`=0.
- Reset during any state: the next cycle is IDLE with all outputs at their reset values. A transfer in flight is dropped, and no `done` is produced.

## Timing
- `start` is sampled at edge E0. Cycle 1 is LOAD (`busy`=1). The first `tx_valid` is in cycle 2.
- With `tx_ready` held at 1, register n loads in cycle 1+9n and sends its bytes in cycles 2+9n..9+9n.
  - The last byte is in cycle 288, `done` in cycle 289, and `busy`=0 from cycle 290.
  - A new `start` is accepted in cycle 290.
- Backpressure: while `tx_valid && !tx_ready`, `tx_data` and `tx_last` are held stable. `tx_valid` never drops before a transfer.
- Between registers, `tx_valid` is low for exactly one cycle (the LOAD cycle).
- `rd` must settle within the LOAD cycle. There is no extra read latency.

## Structure
- Shared package `regdump_pkg` holds:
  - the state enum {IDLE, LOAD, SEND, DONE};
  - `NREGS`, `ABITS`, `DW` defaults;
  - the byte count constant `DW/8`.
- One natural sub-module, `word_serializer`:
  - parallel load of DW bits, shift out 8 bits per handshake;
  - owns shreg and bcnt;
  - outputs `tx_data` and a `word_done` strobe to the top FSM.
- The top level holds the FSM, idx, `ra`, `busy`, `done` and `tx_last`.

## Test plan
- Register file preloaded with Xi=i and X31=0, `start` pulsed, `tx_ready`=1:
  - 256 bytes arrive; bytes 0..7 are 00 00 00 00 00 00 00 00 and bytes 8..15 are 01 00 00 00 00 00 00 00;
  - `tx_last` is high only on byte 255, `done` in cycle 289 and `busy` falls in cycle 290.
- X5=0x0123456789ABCDEF with random `tx_ready` (50%):
  - the register-5 bytes are EF CD AB 89 67 45 23 01;
  - `tx_data` is stable while `tx_valid` is high and `tx_ready` is low;
  - no byte is dropped or duplicated.
- Datapath writes X20←0xFF during the dump, while X3 is being sent: the dump shows X20=0xFF.
- `start` held high for the whole dump and re-pulsed in the DONE cycle: exactly one dump occurs, then a second dump starts in cycle 290 because `start` is still high.
- `reset` asserted mid-SEND of X10 with `tx_ready`=0:
  - the next cycle has `tx_valid`=0, `busy`=0 and `ra`=0, with no `done`;
  - a later `start` restarts cleanly from X0.
- `tx_ready` held at 0 for 100 cycles on byte 0 of X0: the FSM stays in SEND with `tx_data`=0x00, and resumes with the correct sequence once `tx_ready`=1.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NREGS_DEFAULT = 32;
  localparam int ABITS_DEFAULT = 5;
  localparam int DW_DEFAULT    = 64;
  localparam int NBYTES        = DW_DEFAULT / 8;

endpackage

// File: rtl/regfile_dump_if.sv
// Byte stream toward the host/debug link.
// Handshake: a byte moves on a rising edge where tx_valid && tx_ready; once
// tx_valid rises, tx_data/tx_last hold and tx_valid stays high until that edge.
interface regfile_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/regfile_dump_word_serializer.sv
// Parallel-load shift register that emits one DW-bit word as bytes, LSB first.
module word_serializer #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          fire_i,
  output logic [7:0]    tx_data_o,
  output logic          word_done_o,
  output logic          last_byte_o
);
  localparam int NB = DW / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic [DW-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  assign last_byte_o = (bcnt_q == BW'(NB - 1));
  assign word_done_o = fire_i && last_byte_o;
  assign tx_data_o   = shreg_q[7:0];

  // The final byte's accept leaves the word in place; the next load replaces it.
  always_comb begin
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    if (load_i) begin
      shreg_d = data_i;
      bcnt_d  = '0;
    end else if (fire_i && !last_byte_o) begin
      shreg_d = shreg_q >> 8;
      bcnt_d  = bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      bcnt_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
    end
  end
endmodule

// File: rtl/regfile_dump.sv
// Walks register addresses 0..NREGS-1 through a spare read port and streams
// each captured word out byte-serially, little-endian.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int ABITS = ABITS_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [ABITS-1:0] ra,
  input  logic [DW-1:0]    rd,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state,
  regfile_dump_if.master   tx
);
  state_t           state_q, state_d;
  logic [ABITS-1:0] idx_q, idx_d;
  logic             load, fire, word_done, last_byte, last_reg;

  assign last_reg  = (idx_q == ABITS'(NREGS - 1));
  assign fire      = tx.tx_valid && tx.tx_ready;
  assign ra        = idx_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign tx.tx_last = (state_q == SEND) && last_reg && last_byte;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load        = 1'b0;
    tx.tx_valid = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        if (word_done) begin
          if (last_reg) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ABITS'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  word_serializer #(.DW(DW)) u_ser (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .data_i      (rd),
    .fire_i      (fire),
    .tx_data_o   (tx.tx_data),
    .word_done_o (word_done),
    .last_byte_o (last_byte)
  );
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: expected byte stream built from register
// contents, checked every cycle, plus literal spot checks.
module tb_regfile_dump;
  import regdump_pkg::*;

  localparam int NR = 32;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  ra;
  logic [63:0] rd;
  logic        busy, done;
  state_t      dbg_state;

  regfile_dump_if tx_if ();

  regfile_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ra        (ra),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .tx        (tx_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [63:0] regs     [NR];
  logic [63:0] exp_regs [NR];
  assign rd = regs[ra];

  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] rx [0:4095];
  int         rx_cnt = 0;
  int         last_count = 0;
  int         last_seen_idx = -1;
  int         done_count = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  bit         rand_ready = 1'b0;
  bit         ready_force = 1'b0;

  always @(posedge clk) begin
    #2;
    tx_if.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", tx_if.tx_valid, 1);
        chk("hold_data", tx_if.tx_data, prev_data);
      end
      if (tx_if.tx_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_byte: got %0h expected no byte", tx_if.tx_data);
        end else begin
          chk("byte", tx_if.tx_data, exp_q[0]);
          chk("last", tx_if.tx_last, exp_last_q[0]);
          if (tx_if.tx_ready) begin
            if (rx_cnt < 4096) rx[rx_cnt] = tx_if.tx_data;
            if (tx_if.tx_last) begin
              last_count++;
              last_seen_idx = rx_cnt;
            end
            rx_cnt++;
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
      end
      if (done) begin
        done_count++;
        chk("done_after_all", exp_q.size() % (NR * NB), 0);
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp();
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < NB; b++) begin
        exp_q.push_back(exp_regs[r][8*b +: 8]);
        exp_last_q.push_back((r == NR - 1) && (b == NB - 1));
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget, input string name);
    int k = 0;
    while (rx_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, rx_cnt >= target, 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_count < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, done_count >= target, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] x5_lit [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

  initial begin
    int base, dc, done_k;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = 64'(i);
    regs[31] = 64'h0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", tx_if.tx_valid, 0);
    chk("rst_data", tx_if.tx_data, 8'h00);
    chk("rst_last", tx_if.tx_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ra", ra, 0);
    chk("rst_state", dbg_state, IDLE);
    tick();

    // full dump, ready held high, cycle-exact timing
    exp_regs = regs;
    base = rx_cnt;
    ready_force = 1'b1;
    build_exp();
    mon_en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("c1_busy", busy, 1);
        chk("c1_valid", tx_if.tx_valid, 0);
      end
      if (k == 2) chk("c2_valid", tx_if.tx_valid, 1);
      if (k == 10) chk("c10_gap", tx_if.tx_valid, 0);
      if (k == 11) chk("c11_valid", tx_if.tx_valid, 1);
      if (done) begin
        done_k = k;
        break;
      end
    end
    chk("done_cycle", done_k, 289);
    @(negedge clk);
    chk("busy_c290", busy, 0);
    chk("done_pulse", done, 0);
    chk("t1_bytes", rx_cnt - base, 256);
    chk("t1_b0", rx[base + 0], 8'h00);
    chk("t1_b7", rx[base + 7], 8'h00);
    chk("t1_b8", rx[base + 8], 8'h01);
    chk("t1_b9", rx[base + 9], 8'h00);
    chk("t1_b15", rx[base + 15], 8'h00);
    chk("t1_last_cnt", last_count, 1);
    chk("t1_last_idx", last_seen_idx - base, 255);
    tick();

    // X5 pattern with random backpressure
    regs[5] = 64'h0123456789ABCDEF;
    exp_regs = regs;
    base = rx_cnt;
    dc = done_count;
    build_exp();
    rand_ready = 1'b1;
    pulse_start();
    wait_done(dc + 1, 3000, "t2_done_timeout");
    rand_ready = 1'b0;
    ready_force = 1'b1;
    chk("t2_bytes", rx_cnt - base, 256);
    for (int b = 0; b < 8; b++) chk("t2_x5_byte", rx[base + 40 + b], x5_lit[b]);
    regs[5] = 64'd5;
    tick();

    // datapath write to X20 while X3 is on the wire
    exp_regs = regs;
    exp_regs[20] = 64'hFF;
    base = rx_cnt;
    dc = done_count;
    build_exp();
    pulse_start();
    wait_bytes(base + 26, 400, "t3_x3_timeout");
    regs[20] = 64'hFF;
    wait_done(dc + 1, 600, "t3_done_timeout");
    chk("t3_x20_b0", rx[base + 160], 8'hFF);
    chk("t3_x20_b1", rx[base + 161], 8'h00);
    regs[20] = 64'd20;
    tick();

    // start held high throughout: one dump, then an immediate second one
    exp_regs = regs;
    base = rx_cnt;
    dc = done_count;
    build_exp();
    build_exp();
    start = 1'b1;
    tick();
    done_k = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (done) begin
        done_k = k;
        break;
      end
    end
    chk("t4_done_cycle", done_k, 289);
    @(negedge clk);
    chk("t4_c290_busy", busy, 0);
    chk("t4_c290_state", dbg_state, IDLE);
    @(negedge clk);
    chk("t4_c291_busy", busy, 1);
    chk("t4_c291_state", dbg_state, LOAD);
    tick();
    start = 1'b0;
    wait_done(dc + 2, 600, "t4_done2_timeout");
    chk("t4_done_cnt", done_count - dc, 2);
    chk("t4_bytes", rx_cnt - base, 512);
    tick();

    // reset mid-SEND of X10 while stalled
    exp_regs = regs;
    base = rx_cnt;
    dc = done_count;
    build_exp();
    pulse_start();
    wait_bytes(base + 83, 400, "t5_x10_timeout");
    ready_force = 1'b0;
    tick();
    tick();
    chk("t5_stall_state", dbg_state, SEND);
    reset = 1'b1;
    mon_en = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", tx_if.tx_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ra", ra, 0);
    chk("t5_done", done, 0);
    chk("t5_done_cnt", done_count - dc, 0);
    exp_q.delete();
    exp_last_q.delete();
    ready_force = 1'b1;
    tick();
    base = rx_cnt;
    dc = done_count;
    build_exp();
    mon_en = 1'b1;
    pulse_start();
    wait_done(dc + 1, 600, "t5_done_timeout");
    chk("t5_bytes", rx_cnt - base, 256);
    chk("t5_x10_b0", rx[base + 80], 8'h0A);
    tick();

    // 100 cycles of backpressure on the very first byte
    exp_regs = regs;
    base = rx_cnt;
    dc = done_count;
    build_exp();
    ready_force = 1'b0;
    tick();
    pulse_start();
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 2 || k == 50 || k == 101) begin
        chk("t6_state", dbg_state, SEND);
        chk("t6_data", tx_if.tx_data, 8'h00);
      end
    end
    chk("t6_no_bytes", rx_cnt - base, 0);
    tick();
    ready_force = 1'b1;
    wait_done(dc + 1, 600, "t6_done_timeout");
    chk("t6_bytes", rx_cnt - base, 256);
    chk("t6_b8", rx[base + 8], 8'h01);
    tick();
    mon_en = 1'b0;
    chk("exp_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
